// File: rtl/serial_pkg.sv
// Shared definitions for the serializer/deserializer pair: FSM states,
// bit-order encodings and the word-position counter width.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam bit LSB_FIRST_ORDER = 1'b1;
  localparam bit MSB_FIRST_ORDER = 1'b0;

  // Counter width for a word of w bits; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter for one word: clears on demand, counts up on inc,
// and flags the terminal position WIDTH-1.
module bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CE,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count_q;

  // NOTE: flops take non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else if (CE) begin
      if (clr) begin
        count_q <= '0;
      end else if (inc) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign tc = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per beat, with no bubble between words.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = LSB_FIRST_ORDER
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic             O,
  output logic             O_valid,
  output logic             O_last,
  input  logic             O_ready
);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             tc;
  logic             load;
  logic             beat;

  assign O_valid = (state_q == SHIFT);
  assign O_last  = O_valid & tc;
  assign O       = O_valid & (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);

  // Accepting on the last beat lets the next word follow without a gap.
  assign I_ready = CE & ((state_q == IDLE) | (O_last & O_ready));
  assign load    = CE & I_valid & I_ready;
  assign beat    = CE & O_valid & O_ready;

  assign shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                             : {shreg_q[WIDTH-2:0], 1'b0};

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .CLK  (CLK),
    .RESET(RESET),
    .CE   (CE),
    .clr  (load | (beat & O_last)),
    .inc  (beat & ~O_last),
    .tc   (tc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            shreg_q <= I;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (!O_last) begin
              shreg_q <= shreg_d;
            end else if (load) begin
              shreg_q <= I;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one LSB-first and one MSB-first
// instance; expected bits are queued when words are driven.
module tb_piso_serializer;

  logic       CLK;
  logic       RESET;
  logic       CE;

  logic [7:0] i_l, i_m;
  logic       iv_l, iv_m;
  logic       ir_l, ir_m;
  logic       o_l, o_m;
  logic       ov_l, ov_m;
  logic       ol_l, ol_m;
  logic       or_l, or_m;

  int errors = 0;
  int checks = 0;

  bit [1:0] q_l[$];   // {bit, last}
  bit [1:0] q_m[$];

  bit   hold_q[2];
  logic prev_o[2];
  logic prev_last[2];

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .I(i_l), .I_valid(iv_l), .I_ready(ir_l),
    .O(o_l), .O_valid(ov_l), .O_last(ol_l), .O_ready(or_l)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .I(i_m), .I_valid(iv_m), .I_ready(ir_m),
    .O(o_m), .O_valid(ov_m), .O_last(ol_m), .O_ready(or_m)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Queue the expected serial bits of one word at the moment it is driven.
  task automatic push_word(input bit msb, input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      bit b;
      b = msb ? w[7-k] : w[k];
      if (msb) q_m.push_back({b, (k == 7)});
      else     q_l.push_back({b, (k == 7)});
    end
  endtask

  task automatic mon(input int id, input logic o, input logic v, input logic last,
                     input logic rdy);
    bit [1:0] e;
    int       sz;
    if (hold_q[id]) begin
      check(id ? "msb_hold_valid" : "lsb_hold_valid", v, 1);
      check(id ? "msb_hold_o" : "lsb_hold_o", o, prev_o[id]);
      check(id ? "msb_hold_last" : "lsb_hold_last", last, prev_last[id]);
    end
    if (CE && v && rdy && !RESET) begin
      sz = id ? q_m.size() : q_l.size();
      check(id ? "msb_sb_nonempty" : "lsb_sb_nonempty", sz != 0, 1);
      if (sz != 0) begin
        e = id ? q_m.pop_front() : q_l.pop_front();
        check(id ? "msb_bit" : "lsb_bit", o, e[1]);
        check(id ? "msb_last" : "lsb_last", last, e[0]);
      end
    end
    hold_q[id]    = v && !(CE && rdy) && !RESET;
    prev_o[id]    = o;
    prev_last[id] = last;
  endtask

  always @(negedge CLK) begin
    mon(0, o_l, ov_l, ol_l, or_l);
    mon(1, o_m, ov_m, ol_m, or_m);
  end

  initial begin
    RESET = 1'b1; CE = 1'b1;
    i_l = '0; iv_l = 1'b0; or_l = 1'b1;
    i_m = '0; iv_m = 1'b0; or_m = 1'b1;

    // Reset then idle
    tick(); tick();
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("rst_lsb_valid", ov_l, 0);
      check("rst_lsb_o", o_l, 0);
      check("rst_lsb_ready", ir_l, 1);
      check("rst_msb_valid", ov_m, 0);
      check("rst_msb_ready", ir_m, 1);
      tick();
    end

    // Single word LSB-first
    i_l = 8'hA5; iv_l = 1'b1; push_word(0, 8'hA5);
    tick();
    iv_l = 1'b0;
    @(negedge CLK);
    check("a5_first_valid", ov_l, 1);
    check("a5_busy_ready", ir_l, 0);
    repeat (8) tick();
    @(negedge CLK);
    check("a5_idle_valid", ov_l, 0);
    check("a5_sb_empty", q_l.size(), 0);

    // MSB-first with sink stalls
    i_m = 8'h3C; iv_m = 1'b1; push_word(1, 8'h3C);
    tick();
    iv_m = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      or_m = k[0];
      tick();
    end
    or_m = 1'b1;
    @(negedge CLK);
    check("3c_idle_valid", ov_m, 0);
    check("3c_sb_empty", q_m.size(), 0);

    // Back-to-back words
    i_l = 8'hFF; iv_l = 1'b1; push_word(0, 8'hFF);
    tick();
    i_l = 8'h00; push_word(0, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      check("b2b_valid", ov_l, 1);
      if (k == 4) check("b2b_busy_ready", ir_l, 0);
      if (k == 8) check("b2b_last_ready", ir_l, 1);
      tick();
      if (k == 8) iv_l = 1'b0;
    end
    @(negedge CLK);
    check("b2b_idle_valid", ov_l, 0);
    check("b2b_sb_empty", q_l.size(), 0);

    // Busy backpressure: next word presented on cycle 3
    i_l = 8'h6E; iv_l = 1'b1; push_word(0, 8'h6E);
    tick();
    iv_l = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        i_l = 8'h81; iv_l = 1'b1; push_word(0, 8'h81);
      end
      @(negedge CLK);
      if (k >= 3 && k <= 7) check("bp_busy_ready", ir_l, 0);
      if (k == 8) check("bp_last_ready", ir_l, 1);
      tick();
      if (k == 8) iv_l = 1'b0;
    end
    @(negedge CLK);
    check("bp_idle_valid", ov_l, 0);
    check("bp_sb_empty", q_l.size(), 0);

    // CE freeze at bit 4, then reset at bit 5
    i_l = 8'hC3; iv_l = 1'b1; push_word(0, 8'hC3);
    tick();
    iv_l = 1'b0;
    repeat (4) tick();
    CE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("ce_frozen_bit4", o_l, 0);
      check("ce_ready_low", ir_l, 0);
      tick();
    end
    CE = 1'b1;
    tick();
    RESET = 1'b1; or_l = 1'b0;
    tick();
    RESET = 1'b0; or_l = 1'b1;
    q_l.delete();
    @(negedge CLK);
    check("rst_mid_valid", ov_l, 0);
    check("rst_mid_o", o_l, 0);
    check("rst_mid_ready", ir_l, 1);
    tick(); tick();
    @(negedge CLK);
    check("rst_mid_still_idle", ov_l, 0);
    i_l = 8'h5A; iv_l = 1'b1; push_word(0, 8'h5A);
    tick();
    iv_l = 1'b0;
    repeat (9) tick();
    @(negedge CLK);
    check("5a_idle_valid", ov_l, 0);
    check("5a_sb_empty", q_l.size(), 0);
    check("msb_sb_empty_end", q_m.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
